// File: rtl/adsb_frame_assembler.sv
// adsb_frame_assembler
//
// Sits behind the PPM demodulator and turns its per-bit decisions into
// complete Mode-S / ADS-B frames. The first downlink-format bit decides
// between a 56-bit short frame and a 112-bit long frame. While bits arrive
// the CRC-24 remainder is built bit-serially and low-confidence bits are
// counted. A finished frame is offered to the host/FIFO through a single
// output slot with a valid/ready handshake.
//
// Compile-time option:
//   ADSB_DROP_BADCRC_EN - when defined, frames with a nonzero syndrome are
//                         silently discarded. When undefined they are
//                         forwarded with frm_crc_ok=0 so downstream logic
//                         can attempt correction or address-parity recovery.
//
// Ports:
//   clock         main system clock
//   reset         asynchronous active-low reset
//   bit_ena       single-cycle bit strobe from the demodulator
//   bit_data      bit value, valid with bit_ena
//   bit_conf      bit confidence (1 = good), valid with bit_ena
//   frame_start   single-cycle preamble/data-start pulse
//   frame_done    single-cycle end-of-energy pulse
//   frm_data      assembled frame, first bit in the MSB of the used field;
//                 short frames sit right-justified in [55:0]
//   frm_long      1 = 112-bit frame
//   frm_syndrome  CRC-24 remainder over all frame bits
//   frm_crc_ok    frm_syndrome == 0
//   frm_lowconf   number of bits received with bit_conf = 0
//   frm_valid     output slot holds a frame
//   frm_ready     consumer takes the frame when frm_valid & frm_ready
//   overrun       one-cycle pulse: a completed frame was lost (slot full)

module adsb_frame_assembler #(
  parameter int          LOWCONF_MAX = 7,
  parameter logic [23:0] CRC_POLY    = 24'hFFF409
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         bit_ena,
  input  logic         bit_data,
  input  logic         bit_conf,
  input  logic         frame_start,
  input  logic         frame_done,
  output logic [111:0] frm_data,
  output logic         frm_long,
  output logic [23:0]  frm_syndrome,
  output logic         frm_crc_ok,
  output logic [6:0]   frm_lowconf,
  output logic         frm_valid,
  input  logic         frm_ready,
  output logic         overrun
);

  localparam logic [6:0] LC_MAX    = 7'(LOWCONF_MAX);
  localparam logic [6:0] LEN_SHORT = 7'd56;
  localparam logic [6:0] LEN_LONG  = 7'd112;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Collection datapath
  logic [111:0] r_shreg;
  logic [6:0]   r_bitCnt;
  logic [23:0]  r_crc;
  logic [6:0]   r_lowconf;
  logic         r_isLong;

  // Output slot
  logic [111:0] r_frmData;
  logic         r_frmLong;
  logic [23:0]  r_frmSyndrome;
  logic         r_frmCrcOk;
  logic [6:0]   r_frmLowconf;
  logic         r_frmValid;
  logic         r_overrun;

  // Combinational helpers
  logic [6:0]   w_target;
  logic         w_lastBit;
  logic         w_takeBit;
  logic         w_clear;
  logic         w_fb;
  logic [23:0]  w_crcNext;
  logic         w_lowconfOk;
  logic         w_accept;
  logic         w_slotFree;
  logic         w_load;
  logic         w_drop;

  // The DF field's MSB (first received bit) is latched on bit 0, so the
  // target length is already settled long before it is compared against.
  assign w_target  = r_isLong ? LEN_LONG : LEN_SHORT;
  assign w_lastBit = (r_bitCnt == (w_target - 7'd1));

  // frame_start always wins: it restarts collection from any state and a
  // bit strobe arriving in the same cycle belongs to the abandoned frame.
  assign w_clear   = frame_start;
  assign w_takeBit = (r_state == COLLECT) && bit_ena && !frame_start;

  // Bit-serial CRC-24: shift left, fold the generator in on feedback.
  assign w_fb      = r_crc[23] ^ bit_data;
  assign w_crcNext = {r_crc[22:0], 1'b0} ^ (w_fb ? CRC_POLY : 24'h000000);

  assign w_lowconfOk = (r_lowconf <= LC_MAX);

`ifdef ADSB_DROP_BADCRC_EN
  assign w_accept = w_lowconfOk && (r_crc == 24'h000000);
`else
  assign w_accept = w_lowconfOk;
`endif

  assign w_slotFree = !r_frmValid || frm_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. In COLLECT, a frame_done that coincides with the
  // final bit strobe still completes the frame because the bit check is
  // evaluated first.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_nextState = COLLECT;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          w_nextState = COLLECT;
        end else if (bit_ena && w_lastBit) begin
          w_nextState = CHECK;
        end else if (frame_done) begin
          w_nextState = IDLE;
        end
      end
      CHECK: begin
        if (frame_start) begin
          w_nextState = COLLECT;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output decode: CHECK either loads the slot, reports an overrun because
  // the slot is still occupied, or quietly drops a rejected frame.
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    if (r_state == CHECK && w_accept) begin
      w_load = w_slotFree;
      w_drop = !w_slotFree;
    end
  end

  // Collection datapath. The shift register starts from zero, so a short
  // frame naturally ends up right-justified with the upper half clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg   <= '0;
      r_bitCnt  <= '0;
      r_crc     <= '0;
      r_lowconf <= '0;
      r_isLong  <= 1'b0;
    end else if (w_clear) begin
      r_shreg   <= '0;
      r_bitCnt  <= '0;
      r_crc     <= '0;
      r_lowconf <= '0;
      r_isLong  <= 1'b0;
    end else if (w_takeBit) begin
      r_shreg  <= {r_shreg[110:0], bit_data};
      r_bitCnt <= r_bitCnt + 7'd1;
      r_crc    <= w_crcNext;
      if (!bit_conf && (r_lowconf != 7'h7F)) begin
        r_lowconf <= r_lowconf + 7'd1;
      end
      if (r_bitCnt == 7'd0) begin
        r_isLong <= bit_data;
      end
    end
  end

  // Output slot. A load in the same cycle as a consumer handshake keeps
  // frm_valid high so the new frame follows without a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frmData     <= '0;
      r_frmLong     <= 1'b0;
      r_frmSyndrome <= '0;
      r_frmCrcOk    <= 1'b0;
      r_frmLowconf  <= '0;
      r_frmValid    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_load) begin
        r_frmData     <= r_shreg;
        r_frmLong     <= r_isLong;
        r_frmSyndrome <= r_crc;
        r_frmCrcOk    <= (r_crc == 24'h000000);
        r_frmLowconf  <= r_lowconf;
        r_frmValid    <= 1'b1;
      end else if (r_frmValid && frm_ready) begin
        r_frmValid <= 1'b0;
      end
    end
  end

  assign frm_data     = r_frmData;
  assign frm_long     = r_frmLong;
  assign frm_syndrome = r_frmSyndrome;
  assign frm_crc_ok   = r_frmCrcOk;
  assign frm_lowconf  = r_frmLowconf;
  assign frm_valid    = r_frmValid;
  assign overrun      = r_overrun;

endmodule
